// File: rtl/mileage_display.sv
// Odometer count to 8-digit BCD (sequential double-dabble) and a multiplexed
// 7-segment scan driver with leading-zero blanking and a display-enable gate.
module mileage_display #(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned SCAN_HZ       = 1000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        display_en,
    input  logic [26:0] record,
    output logic [7:0]  an_en,
    output logic [7:0]  seg_code,
    output logic [31:0] bcd,
    output logic        busy
);

    localparam int unsigned REC_W  = 27;
    localparam int unsigned BCD_W  = 32;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned ITER_W = 5;
    localparam int unsigned DIV    = (CLK_FREQ / SCAN_HZ > 0) ? CLK_FREQ / SCAN_HZ : 1;
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [REC_W-1:0]  REC_MAX   = REC_W'(9_999_999);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(REC_W - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t              state;
    logic [REC_W-1:0]    sampled;
    logic [REC_W-1:0]    bin_sr;
    logic [BCD_W-1:0]    work;
    logic [ITER_W-1:0]   iter;

    logic [BCD_W-1:0]    work_adj;
    logic [BCD_W-1:0]    work_sh;
    logic [REC_W-1:0]    bin_sh;

    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    idx;
    logic [DIGITS-1:0]   lead_zero;
    logic [3:0]          cur_digit;
    logic [7:0]          cur_code;

    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = 8'h3F;
            4'd1:    code = 8'h06;
            4'd2:    code = 8'h5B;
            4'd3:    code = 8'h4F;
            4'd4:    code = 8'h66;
            4'd5:    code = 8'h6D;
            4'd6:    code = 8'h7D;
            4'd7:    code = 8'h07;
            4'd8:    code = 8'h7F;
            4'd9:    code = 8'h6F;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    // Double-dabble step: add-3 correction on every nibble >= 5, then shift left.
    always_comb begin
        work_adj = work;
        for (int n = 0; n < DIGITS; n++) begin
            if (work[n*4 +: 4] >= 4'd5) begin
                work_adj[n*4 +: 4] = work[n*4 +: 4] + 4'd3;
            end
        end
    end

    assign {work_sh, bin_sh} = {work_adj[BCD_W-2:0], bin_sr, 1'b0};

    // Conversion FSM; sampled keeps the raw count so clamped inputs do not retrigger.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sampled <= '0;
            bin_sr  <= '0;
            work    <= '0;
            iter    <= '0;
            bcd     <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (record != sampled) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    sampled <= record;
                    bin_sr  <= (record > REC_MAX) ? REC_MAX : record;
                    work    <= '0;
                    iter    <= '0;
                    busy    <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    work   <= work_sh;
                    bin_sr <= bin_sh;
                    iter   <= iter + ITER_W'(1);
                    if (iter == LAST_ITER) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    bcd   <= work;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digit k is a leading zero when it and every digit above it are zero; units never blank.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run          = run && (bcd[k*4 +: 4] == 4'd0);
            lead_zero[k] = run;
        end
    end

    assign cur_digit = bcd[{idx, 2'b00} +: 4];
    assign cur_code  = (BLANK_LEADING && lead_zero[idx]) ? 8'h00 : seg_encode(cur_digit);

    // Scan divider and registered anode/segment drive, updated together every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            idx      <= '0;
            an_en    <= '0;
            seg_code <= '0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                idx     <= idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            an_en    <= (DIGITS'(1) << idx) & {DIGITS{display_en}};
            seg_code <= cur_code;
        end
    end

endmodule

// File: doc/mileage_display.md
Name: mileage_display

Overview:
- Downstream consumer of the 27-bit manual-gear odometer count.
- Converts the count to 8 BCD digits with a sequential double-dabble FSM and drives the 8-digit multiplexed 7-segment display.
- Includes leading-zero blanking and a display-enable gate.
- Sits between the odometer counter and the board segment/anode pins.

Parameters:
- CLK_FREQ, 100_000_000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz; one digit is lit per tick, so a full 8-digit frame is refreshed at SCAN_HZ/8.
- BLANK_LEADING, 1, when 1 leading zeros are blanked; when 0 all 8 digits are shown.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- display_en  input  1  1 = drive display; 0 = all anodes off (conversion continues).
- record  input  27  odometer count, nominal range 0..9_999_999.
- an_en  output  8  digit enables, one-hot, active-high; bit0 = rightmost (units) digit.
- seg_code  output  8  segments, active-high, {dp,g,f,e,d,c,b,a}; dp always 0.
- bcd  output  32  latched BCD of the last converted value, bcd[3:0] = units.
- busy  output  1  1 while a conversion is in progress.

Behaviour:
- Reset values, applied asynchronously while rst = 1:
  - FSM = IDLE; an_en = 0; seg_code = 0; bcd = 0; busy = 0.
  - Scan index = 0; scan divider = 0; sampled value = 0.
- Conversion FSM (IDLE, LOAD, SHIFT, LATCH):
  - IDLE: if record != sampled, go to LOAD; else stay.
  - LOAD (1 cycle): sampled <= record; shift reg <= min(record, 9_999_999); work BCD <= 0; iteration counter <= 0; busy <= 1.
  - SHIFT (27 cycles): each cycle, add 3 to every work-BCD nibble >= 5, then shift {BCD, bin} left by 1. After iteration 26, go to LATCH.
  - LATCH (1 cycle): bcd <= work BCD; busy <= 0; return to IDLE.
  - Latency: record change sampled in IDLE -> bcd updated 29 cycles later (LOAD + 27 SHIFT + LATCH).
- Clamp: record values > 9_999_999 (up to 2^27-1) convert as 9_999_999. sampled holds the raw value, so no re-trigger loop.
- Record change mid-conversion: ignored; the in-flight conversion completes with the old value. Next IDLE cycle sees the mismatch and restarts. bcd never shows a partial value.
- Scan divider:
  - Counts 0..CLK_FREQ/SCAN_HZ-1; tick on terminal count; index increments mod 8 on tick.
  - Outputs are registered: an_en = one-hot(index) & {8{display_en}}; seg_code = encode(digit[index]), registered on the same edge, so an_en and seg_code change together.
- Encoding: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; blank = 00. Nibbles > 9 are impossible; encode them as 00.
- Blanking (BLANK_LEADING = 1):
  - Digit k is blank if all of digits k..7 are zero and k != 0.
  - Units digit is always shown, so a value of 0 shows a single "0".
  - A blanked digit drives seg_code = 00 while its an_en bit is still asserted.
- display_en = 0: an_en = 00 within 1 cycle; seg_code keeps scanning; bcd keeps updating.
- Reset mid-conversion: FSM returns to IDLE, sampled = 0. After release, a nonzero record triggers a fresh conversion.

Test Plan:
- Reset then record = 0, display_en = 1, CLK_FREQ = 800, SCAN_HZ = 100 (tick every 8 clk) -> bcd = 0x00000000, busy never rises; index 0 shows an_en = 01, seg_code = 3F; indices 1..7 show seg_code = 00.
- record 0 -> 1234567 -> busy high for 28 cycles; bcd = 0x01234567 exactly 29 cycles after the change; the scan frame shows digits 7,6,5,4,3,2,1 with codes 07,7D,6D,66,4F,5B,06 and digit 7 blank.
- record = 27'h7FFFFFF -> bcd = 0x09999999, all 7 low digits encode 6F; the FSM settles in IDLE with no retrigger.
- record changes 100 -> 200 at SHIFT iteration 10 -> bcd first becomes 0x00000100, then 0x00000200 after a second 29-cycle conversion.
- display_en toggled 1->0->1 mid-frame -> an_en = 00 on the next edge after the drop; scan index unaffected; resumes at the current index.
- rst asserted during SHIFT and asynchronously mid-cycle -> all outputs 0 immediately; after release with record = 42, bcd = 0x00000042.
